// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per CALC cycle; the result is registered on entry to DONE.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   rem, quo, dvsr;
  logic [CNT_W-1:0]   cnt;
  logic               op_rem, neg_q, neg_r;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic             signed_op, dvd_neg, dvs_neg, div_zero, ovf, special, accept;
  logic [WIDTH-1:0] special_res;

  assign signed_op = ~op_i[0];
  assign dvd_neg   = signed_op & dividend_i[WIDTH-1];
  assign dvs_neg   = signed_op & divisor_i[WIDTH-1];
  assign div_zero  = (divisor_i == '0);
  assign ovf       = signed_op && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_i == '1);
  assign special   = div_zero | ovf;
  assign accept    = (state == IDLE) && start_i && !flush_i;

  // Overflow quotient equals the dividend (most-negative value) itself
  assign special_res = op_i[1] ? (div_zero ? dividend_i : '0)
                               : (div_zero ? '1 : dividend_i);

  // Trial subtraction on the shifted partial remainder
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] r_step, q_step, final_res;

  assign rem_sh    = {rem, quo[WIDTH-1]};
  assign trial     = rem_sh - {1'b0, dvsr};
  assign r_step    = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_step    = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign final_res = op_rem ? cond_neg(r_step, neg_r) : cond_neg(q_step, neg_q);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      op_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
    end else if (accept) begin
      if (special) begin
        result_o <= special_res;
      end else begin
        rem    <= '0;
        quo    <= cond_neg(dividend_i, dvd_neg);
        dvsr   <= cond_neg(divisor_i, dvs_neg);
        cnt    <= CNT_W'(WIDTH);
        op_rem <= op_i[1];
        neg_q  <= dvd_neg ^ dvs_neg;
        neg_r  <= dvd_neg;
      end
    end else if (state == CALC && !flush_i) begin
      rem <= r_step;
      quo <= q_step;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) result_o <= final_res;
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, handshake, flush,
// mid-operation reset and randomized operations against an arithmetic model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_res = '0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .op_i(op),
    .dividend_i(dividend), .divisor_i(divisor), .flush_i(flush),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V M-extension semantics with plain integer arithmetic
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    if (o[0]) return o[1] ? a % b : a / b;
    sa = a;
    sb = b;
    return o[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int lat, exp_lat;
    exp     = model(o, a, b);
    exp_lat = is_special(o, a, b) ? 1 : 33;
    start = 1'b1; op = o; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp);
    @(posedge clk); #1;
    check({tag, " busy/done after"}, {30'b0, busy, done}, 32'h0);
    last_res = exp;
  endtask

  initial begin
    int lat, ndone;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #22;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("DIVU 100/7", 2'b01, 32'd100, 32'd7);
    do_op("REMU 100/7", 2'b11, 32'd100, 32'd7);
    do_op("DIV -7/2", 2'b00, -32'sd7, 32'd2);
    do_op("REM -7/2", 2'b10, -32'sd7, 32'd2);
    do_op("DIV 7/-2", 2'b00, 32'd7, -32'sd2);
    do_op("REM 7/-2", 2'b10, 32'd7, -32'sd2);
    do_op("DIVU x/0", 2'b01, 32'h1234, 32'h0);
    do_op("REM -5/0", 2'b10, -32'sd5, 32'h0);
    do_op("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

    // start held high; later operand changes must be ignored while busy
    start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    dividend = 32'd50; divisor = 32'd5;
    lat = 1; ndone = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold latency", 32'(lat), 32'd33);
    check("hold result", result, 32'd14);
    @(posedge clk); #1;
    check("hold busy idle", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    check("hold restart busy", {31'b0, busy}, 32'h1);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("restart latency", 32'(lat), 32'd33);
    check("restart result", result, 32'd10);
    last_res = 32'd10;
    @(posedge clk); #1;

    // flush in cycle k+10
    start = 1'b1; op = 2'b00; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 32'h0);
    ndone = 0;
    repeat (40) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("flush no done", 32'(ndone), 32'h0);
    check("flush result kept", result, last_res);
    do_op("DIVU 9/3", 2'b01, 32'd9, 32'd3);

    // asynchronous reset in cycle k+5
    start = 1'b1; op = 2'b01; dividend = 32'h1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("arst busy", {31'b0, busy}, 32'h0);
    check("arst done", {31'b0, done}, 32'h0);
    check("arst result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("DIVU max/1", 2'b01, 32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = -32'($urandom_range(1, 15));
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
